// File: rtl/multi_digit_counter_7sd.sv
// ---------------------------------------------------------------------------
// multi_digit_counter_7sd
//
// Multi-digit up/down counter with active-low seven-segment drive and a
// mode state machine (IDLE -> AUTO -> SWITCH -> BIT -> AUTO).
//
// Build option:
//   MULTI_DIGIT_COUNTER_7SD_BCD_EN  defined   : each digit counts 0-9 (BCD)
//                                   undefined : plain binary (hex digits)
//
// Ports:
//   i_Clk        system clock, rising edge
//   i_Reset      asynchronous active-high reset
//   i_Mode_Btn   debounced level, rising edge advances the mode
//   i_Step_Btn   debounced level, rising edge steps the count in SWITCH
//   i_Clear_Btn  debounced level, rising edge clears the count
//   i_Dir        0 = count up, 1 = count down
//   i_Bits       debounced switches, rising edge on bit k toggles count bit k
//   o_Mode       0 IDLE, 1 AUTO, 2 SWITCH, 3 BIT
//   o_Count      count, digit 0 in [3:0]
//   o_Segments   active-low segments, digit d in [7d+6:7d], bit order A..G
//   o_Carry      one-cycle pulse on wrap-around
// ---------------------------------------------------------------------------
module multi_digit_counter_7sd #(
   parameter int unsigned NUM_DIGITS = 2,
   parameter int unsigned AUTO_DIV   = 25_000_000
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset,
   input  logic                      i_Mode_Btn,
   input  logic                      i_Step_Btn,
   input  logic                      i_Clear_Btn,
   input  logic                      i_Dir,
   input  logic [3:0]                i_Bits,
   output logic [1:0]                o_Mode,
   output logic [4*NUM_DIGITS-1:0]   o_Count,
   output logic [7*NUM_DIGITS-1:0]   o_Segments,
   output logic                      o_Carry
);

   localparam int unsigned PW = $clog2(AUTO_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);
   localparam logic [6:0] DASH = 7'b0111111;

`ifdef MULTI_DIGIT_COUNTER_7SD_BCD_EN
   localparam logic [3:0] DIGIT_MAX = 4'd9;
`else
   localparam logic [3:0] DIGIT_MAX = 4'd15;
`endif

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_AUTO   = 2'd1,
      MODE_SWITCH = 2'd2,
      MODE_BIT    = 2'd3
   } mode_t;

   mode_t                    mode;
   logic [4*NUM_DIGITS-1:0]  count;
   logic [PW-1:0]            presc;

   // Sample register plus previous-sample register per input line
   logic       mode_s, mode_p, step_s, step_p, clear_s, clear_p;
   logic [3:0] bits_s, bits_p;

   logic       mode_edge, step_edge, clear_edge;
   logic [3:0] bits_edge;

   assign mode_edge  = mode_s  & ~mode_p;
   assign step_edge  = step_s  & ~step_p;
   assign clear_edge = clear_s & ~clear_p;
   assign bits_edge  = bits_s  & ~bits_p;

   // Digit-wise ripple step; a ripple out of the top digit is a wrap.
   // Sharing this loop keeps hex and BCD on one code path (only DIGIT_MAX differs).
   logic [4*NUM_DIGITS-1:0] step_val;
   logic                    step_wrap;
   logic                    ripple;
   logic [3:0]              digit;

   always_comb begin
      step_val = count;
      ripple   = 1'b1;
      digit    = '0;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         digit = count[4*d +: 4];
         if (ripple) begin
            if (!i_Dir) begin
               if (digit == DIGIT_MAX) digit = '0;
               else begin
                  digit  = digit + 4'd1;
                  ripple = 1'b0;
               end
            end else begin
               if (digit == '0) digit = DIGIT_MAX;
               else begin
                  digit  = digit - 4'd1;
                  ripple = 1'b0;
               end
            end
         end
         step_val[4*d +: 4] = digit;
      end
      step_wrap = ripple;
   end

   logic [3:0] bit_val;

   always_comb begin
      bit_val = count[3:0] ^ bits_edge;
`ifdef MULTI_DIGIT_COUNTER_7SD_BCD_EN
      if (bit_val > 4'd9) bit_val = 4'd9;
`endif
   end

   function automatic logic [6:0] glyph(input logic [3:0] v);
      // Active-high, bit 0 = A ... bit 6 = G
      case (v)
         4'h0: glyph = 7'b0111111;
         4'h1: glyph = 7'b0000110;
         4'h2: glyph = 7'b1011011;
         4'h3: glyph = 7'b1001111;
         4'h4: glyph = 7'b1100110;
         4'h5: glyph = 7'b1101101;
         4'h6: glyph = 7'b1111101;
         4'h7: glyph = 7'b0000111;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1101111;
         4'hA: glyph = 7'b1110111;
         4'hB: glyph = 7'b1111100;
         4'hC: glyph = 7'b0111001;
         4'hD: glyph = 7'b1011110;
         4'hE: glyph = 7'b1111001;
         default: glyph = 7'b1110001;
      endcase
   endfunction

   logic [7*NUM_DIGITS-1:0] seg_next;

   always_comb begin
      seg_next = '1;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         if (mode == MODE_IDLE) seg_next[7*d +: 7] = DASH;
         else                   seg_next[7*d +: 7] = ~glyph(count[4*d +: 4]);
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         mode_s     <= 1'b0;
         mode_p     <= 1'b0;
         step_s     <= 1'b0;
         step_p     <= 1'b0;
         clear_s    <= 1'b0;
         clear_p    <= 1'b0;
         bits_s     <= '0;
         bits_p     <= '0;
         mode       <= MODE_IDLE;
         count      <= '0;
         presc      <= '0;
         o_Carry    <= 1'b0;
         o_Segments <= {NUM_DIGITS{DASH}};
      end else begin
         mode_s  <= i_Mode_Btn;
         mode_p  <= mode_s;
         step_s  <= i_Step_Btn;
         step_p  <= step_s;
         clear_s <= i_Clear_Btn;
         clear_p <= clear_s;
         bits_s  <= i_Bits;
         bits_p  <= bits_s;

         o_Carry    <= 1'b0;
         o_Segments <= seg_next;

         if (clear_edge) begin
            count <= '0;
            presc <= '0;
         end else if (mode_edge) begin
            count <= '0;
            presc <= '0;
            case (mode)
               MODE_IDLE:   mode <= MODE_AUTO;
               MODE_AUTO:   mode <= MODE_SWITCH;
               MODE_SWITCH: mode <= MODE_BIT;
               default:     mode <= MODE_AUTO;
            endcase
         end else begin
            case (mode)
               MODE_IDLE: begin
                  count <= '0;
                  presc <= '0;
               end
               MODE_AUTO: begin
                  if (presc == PRESC_LAST) begin
                     presc   <= '0;
                     count   <= step_val;
                     o_Carry <= step_wrap;
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               MODE_SWITCH: begin
                  if (step_edge) begin
                     count   <= step_val;
                     o_Carry <= step_wrap;
                  end
               end
               default: begin
                  if (|bits_edge) count[3:0] <= bit_val;
               end
            endcase
         end
      end
   end

   assign o_Mode  = mode;
   assign o_Count = count;

endmodule

// File: tb/tb_multi_digit_counter_7sd.sv
module tb_multi_digit_counter_7sd;

   logic        i_Clk;
   logic        i_Reset;
   logic        i_Mode_Btn;
   logic        i_Step_Btn;
   logic        i_Clear_Btn;
   logic        i_Dir;
   logic [3:0]  i_Bits;
   logic [1:0]  o_Mode;
   logic [7:0]  o_Count;
   logic [13:0] o_Segments;
   logic        o_Carry;

   int checks = 0;
   int errors = 0;

   localparam logic [13:0] SEG_DASHES = {7'b0111111, 7'b0111111};
   localparam logic [6:0]  SEG_0 = 7'b1000000;
   localparam logic [6:0]  SEG_3 = 7'b0110000;
   localparam logic [6:0]  SEG_4 = 7'b0011001;

`ifdef MULTI_DIGIT_COUNTER_7SD_BCD_EN
   localparam logic [7:0] E_TOP    = 8'h99;
   localparam logic [7:0] E_TOP_M1 = 8'h98;
   localparam logic [7:0] E_TEN    = 8'h10;
   localparam logic [7:0] E_BIT3   = 8'h09;
`else
   localparam logic [7:0] E_TOP    = 8'hFF;
   localparam logic [7:0] E_TOP_M1 = 8'hFE;
   localparam logic [7:0] E_TEN    = 8'h0A;
   localparam logic [7:0] E_BIT3   = 8'h0C;
`endif

   multi_digit_counter_7sd #(
      .NUM_DIGITS (2),
      .AUTO_DIV   (4)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Mode_Btn  (i_Mode_Btn),
      .i_Step_Btn  (i_Step_Btn),
      .i_Clear_Btn (i_Clear_Btn),
      .i_Dir       (i_Dir),
      .i_Bits      (i_Bits),
      .o_Mode      (o_Mode),
      .o_Count     (o_Count),
      .o_Segments  (o_Segments),
      .o_Carry     (o_Carry)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      i_Mode_Btn = 1'b0; i_Step_Btn = 1'b0; i_Clear_Btn = 1'b0;
      i_Dir = 1'b0; i_Bits = 4'b0000;
      tick_n(2);
      i_Reset = 1'b0;
   endtask

   // Each press returns one cycle after the edge is sampled, i.e. when the
   // resulting count/mode/carry are visible.
   task automatic press_mode();
      i_Mode_Btn = 1'b1; tick(); i_Mode_Btn = 1'b0; tick();
   endtask

   task automatic press_step();
      i_Step_Btn = 1'b1; tick(); i_Step_Btn = 1'b0; tick();
   endtask

   task automatic test_reset();
      i_Reset = 1'b1;
      i_Mode_Btn = 1'b0; i_Step_Btn = 1'b0; i_Clear_Btn = 1'b0;
      i_Dir = 1'b0; i_Bits = 4'b0000;
      #2;
      checks++; if (o_Mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", o_Mode); end
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL reset_count: got %h expected 00", o_Count); end
      checks++; if (o_Carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", o_Carry); end
      checks++; if (o_Segments !== SEG_DASHES) begin errors++; $display("FAIL reset_segments: got %b expected %b", o_Segments, SEG_DASHES); end
      tick();
      i_Reset = 1'b0;
      tick();
      checks++; if (o_Segments !== SEG_DASHES) begin errors++; $display("FAIL idle_segments: got %b expected %b", o_Segments, SEG_DASHES); end
   endtask

   task automatic test_auto();
      do_reset();
      press_mode();
      checks++; if (o_Mode !== 2'd1) begin errors++; $display("FAIL auto_mode: got %0d expected 1", o_Mode); end
      for (int i = 1; i <= 4; i++) begin
         tick_n(3);
         checks++; if (o_Count !== 8'(i - 1)) begin errors++; $display("FAIL auto_hold_%0d: got %h expected %h", i, o_Count, 8'(i - 1)); end
         tick();
         checks++; if (o_Count !== 8'(i)) begin errors++; $display("FAIL auto_step_%0d: got %h expected %h", i, o_Count, 8'(i)); end
      end
      checks++; if (o_Segments[6:0] !== SEG_3) begin errors++; $display("FAIL auto_seg_lag: got %b expected %b", o_Segments[6:0], SEG_3); end
      tick();
      checks++; if (o_Segments !== {SEG_0, SEG_4}) begin errors++; $display("FAIL auto_seg_4: got %b expected %b", o_Segments, {SEG_0, SEG_4}); end
   endtask

   task automatic test_switch_wrap();
      do_reset();
      press_mode();
      press_mode();
      checks++; if (o_Mode !== 2'd2) begin errors++; $display("FAIL switch_mode: got %0d expected 2", o_Mode); end
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL switch_entry_count: got %h expected 00", o_Count); end
      i_Dir = 1'b1;
      press_step();
      checks++; if (o_Count !== E_TOP) begin errors++; $display("FAIL down_wrap_count: got %h expected %h", o_Count, E_TOP); end
      checks++; if (o_Carry !== 1'b1) begin errors++; $display("FAIL down_wrap_carry: got %b expected 1", o_Carry); end
      tick();
      checks++; if (o_Carry !== 1'b0) begin errors++; $display("FAIL carry_one_cycle: got %b expected 0", o_Carry); end
      press_step();
      checks++; if (o_Count !== E_TOP_M1) begin errors++; $display("FAIL down_count: got %h expected %h", o_Count, E_TOP_M1); end
      checks++; if (o_Carry !== 1'b0) begin errors++; $display("FAIL down_no_carry: got %b expected 0", o_Carry); end
      i_Dir = 1'b0;
      press_step();
      checks++; if (o_Count !== E_TOP) begin errors++; $display("FAIL up_to_top: got %h expected %h", o_Count, E_TOP); end
      press_step();
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL up_wrap_count: got %h expected 00", o_Count); end
      checks++; if (o_Carry !== 1'b1) begin errors++; $display("FAIL up_wrap_carry: got %b expected 1", o_Carry); end
      for (int i = 0; i < 10; i++) press_step();
      checks++; if (o_Count !== E_TEN) begin errors++; $display("FAIL up_past_9: got %h expected %h", o_Count, E_TEN); end
      checks++; if (o_Carry !== 1'b0) begin errors++; $display("FAIL up_past_9_carry: got %b expected 0", o_Carry); end
   endtask

   task automatic test_bit();
      // Continues from SWITCH mode
      press_mode();
      checks++; if (o_Mode !== 2'd3) begin errors++; $display("FAIL bit_mode: got %0d expected 3", o_Mode); end
      i_Bits = 4'b0101;
      tick_n(2);
      checks++; if (o_Count !== 8'h05) begin errors++; $display("FAIL bit_multi: got %h expected 05", o_Count); end
      i_Bits = 4'b0100;
      tick();
      i_Bits = 4'b0101;
      tick_n(2);
      checks++; if (o_Count !== 8'h04) begin errors++; $display("FAIL bit_toggle0: got %h expected 04", o_Count); end
      i_Dir = 1'b1;
      press_step();
      checks++; if (o_Count !== 8'h04) begin errors++; $display("FAIL bit_step_ignored: got %h expected 04", o_Count); end
      i_Dir = 1'b0;
      i_Bits = 4'b1101;
      tick_n(2);
      checks++; if (o_Count !== E_BIT3) begin errors++; $display("FAIL bit_toggle3: got %h expected %h", o_Count, E_BIT3); end
      i_Bits = 4'b0000;
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      press_mode();
      press_mode();
      for (int i = 0; i < 5; i++) press_step();
      checks++; if (o_Count !== 8'h05) begin errors++; $display("FAIL prio_setup: got %h expected 05", o_Count); end
      i_Clear_Btn = 1'b1; i_Step_Btn = 1'b1;
      tick();
      i_Clear_Btn = 1'b0; i_Step_Btn = 1'b0;
      tick();
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL clear_step_count: got %h expected 00", o_Count); end
      checks++; if (o_Carry !== 1'b0) begin errors++; $display("FAIL clear_step_carry: got %b expected 0", o_Carry); end
      checks++; if (o_Mode !== 2'd2) begin errors++; $display("FAIL clear_keeps_mode: got %0d expected 2", o_Mode); end
      press_step();
      checks++; if (o_Count !== 8'h01) begin errors++; $display("FAIL prio_step: got %h expected 01", o_Count); end
      i_Mode_Btn = 1'b1; i_Step_Btn = 1'b1;
      tick();
      i_Mode_Btn = 1'b0; i_Step_Btn = 1'b0;
      tick();
      checks++; if (o_Mode !== 2'd3) begin errors++; $display("FAIL mode_step_mode: got %0d expected 3", o_Mode); end
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL mode_step_count: got %h expected 00", o_Count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      press_mode();
      tick_n(8);
      checks++; if (o_Count !== 8'h02) begin errors++; $display("FAIL async_setup: got %h expected 02", o_Count); end
      #3;
      i_Reset = 1'b1;
      #1;
      checks++; if (o_Mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d expected 0", o_Mode); end
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL async_count: got %h expected 00", o_Count); end
      checks++; if (o_Segments !== SEG_DASHES) begin errors++; $display("FAIL async_segments: got %b expected %b", o_Segments, SEG_DASHES); end
      #1;
      i_Reset = 1'b0;
      tick_n(6);
      checks++; if (o_Mode !== 2'd0) begin errors++; $display("FAIL idle_after_reset: got %0d expected 0", o_Mode); end
      checks++; if (o_Count !== 8'h00) begin errors++; $display("FAIL idle_count_held: got %h expected 00", o_Count); end
   endtask

   initial begin
      test_reset();
      test_auto();
      test_switch_wrap();
      test_bit();
      test_priority();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_digit_counter_7sd.md
# multi_digit_counter_7sd

Parametrised multi-digit counter with seven-segment drive. Generalises the single-nibble Go Board counter to `NUM_DIGITS` digits with a carry chain, up/down direction, a clear input and a mode state machine. Modes are IDLE, AUTO, SWITCH and BIT. It sits behind the debounce block and drives the segment pins and LEDs directly.

## Interface

Parameters:
- `NUM_DIGITS`, default 2: number of 4-bit digits; must be ≥1.
- `AUTO_DIV`, default 25_000_000: clocks per AUTO step (1 Hz at 25 MHz); must be ≥2.

Ports:
- `i_Clk`  in  1  system clock; all state on rising edge.
- `i_Reset`  in  1  reset, asynchronous, active-high.
- `i_Mode_Btn`  in  1  debounced level; each rising edge advances the mode.
- `i_Step_Btn`  in  1  debounced level; each rising edge steps the count in SWITCH mode.
- `i_Clear_Btn`  in  1  debounced level; each rising edge clears the count in any mode.
- `i_Dir`  in  1  level; 0 = count up, 1 = count down (AUTO and SWITCH).
- `i_Bits`  in  4  debounced switches; in BIT mode, a rising edge on bit k toggles count bit k.
- `o_Mode`  out  2  current mode: 0 IDLE, 1 AUTO, 2 SWITCH, 3 BIT.
- `o_Count`  out  4*NUM_DIGITS  current count; digit 0 (least significant) in [3:0].
- `o_Segments`  out  7*NUM_DIGITS  active-low segments; digit d in [7d+6:7d], bit order A..G.
- `o_Carry`  out  1  one-cycle pulse on wrap-around in either direction.

## Operation

- Edge detection: each button and `i_Bits` line is registered once, and an edge is current sample 1 with previous sample 0. Inputs are already synchronous (debounced).
- State machine transitions on a mode edge: IDLE→AUTO→SWITCH→BIT→AUTO. IDLE is entered only by reset.
- Every mode change clears the count to 0 and the prescaler to 0.
- IDLE:
  - Count held at 0.
  - Every digit shows segment G only ("-").
- AUTO:
  - Prescaler counts 0..AUTO_DIV-1 and wraps.
  - A tick is generated when the prescaler equals AUTO_DIV-1; the count steps one in direction `i_Dir` on each tick.
- SWITCH: each step edge steps the count once in direction `i_Dir`.
- BIT:
  - Each `i_Bits[k]` edge XORs bit k of `o_Count` (digit 0 only).
  - Simultaneous edges all apply in the same cycle.
  - Step and `i_Dir` are ignored.
- Arithmetic, hex build (default):
  - Count is a plain 4*NUM_DIGITS-bit binary value.
  - Up from all-ones wraps to 0; down from 0 wraps to all-ones.
  - Each wrap pulses `o_Carry`.
- Clear edge:
  - Count becomes 0 and the prescaler becomes 0.
  - Mode is unchanged and `o_Carry` does not pulse.
- Priority within one cycle: reset > clear > mode > step/tick > bit toggle. Lower-priority events in that cycle are dropped.
- Decoding: each digit is decoded 0–F to the standard Go Board glyphs, then inverted for active-low pins.

## Timing

- Reset values, asserted asynchronously:
  - `o_Mode`=0, `o_Count`=0, `o_Carry`=0.
  - Prescaler=0.
  - Each `o_Segments` digit = 7'b0111111 (G lit).
- The input registers reset to 0, so an input already high when reset releases produces one edge on the first clock.
- Latency from an input first sampled high at edge N:
  - `o_Count`, `o_Mode` and `o_Carry` update at edge N+1.
  - `o_Segments` updates at edge N+2.
- AUTO: the first step occurs AUTO_DIV clocks after AUTO is entered; the period is then exactly AUTO_DIV clocks.
- `o_Carry` is high for exactly one cycle, aligned with the `o_Count` wrap value.
- Reset mid-count returns to IDLE immediately; there is no partial update.

## Configuration

- Macro: `MULTI_DIGIT_COUNTER_7SD_BCD_EN`.
- Defined: every digit counts decimal 0–9.
  - Up: 9 rolls to 0 with a carry into the next digit. Full-scale 10^NUM_DIGITS−1 wraps to 0 and pulses `o_Carry`.
  - Down: 0 borrows from the next digit. All-zero wraps to all-nines and pulses `o_Carry`.
  - BIT mode: a toggle that produces a digit value above 9 is forced to 9.
- Undefined: hex/binary behaviour as in Operation.

## Test plan

- Reset, then mode edge, then AUTO_DIV=4 with `i_Dir`=0 for 20 clocks -> `o_Mode`=1 and `o_Count` steps 0,1,2,3,4 at 4-clock intervals. `o_Segments` digit 0 shows "4" one cycle after `o_Count`.
- Hex build, NUM_DIGITS=2, SWITCH mode, `i_Dir`=1, one step edge -> `o_Count`=8'hFF and `o_Carry` pulses one cycle.
- BCD build, SWITCH mode, count 8'h09, step up -> 8'h10 with no carry. At 8'h99, step up -> 8'h00 with `o_Carry`=1.
- BIT mode, `i_Bits` 0000→0101 in one cycle -> `o_Count`[3:0]=4'b0101. A second 0→1 edge on `i_Bits[0]` -> 4'b0100.
- Clear edge and step edge in the same cycle at count 5 -> count 0 and no carry. Mode edge and step edge together in SWITCH -> `o_Mode`=3 and count 0.
- Assert `i_Reset` asynchronously mid-AUTO between clock edges -> outputs return to reset values before the next edge, with `o_Mode`=0 and "-" on all digits.
